// File: rtl/ub_word_loader_pkg.sv
// Shared constants, state encoding and size helpers for the UB word loader.
package ub_loader_pkg;

   // Default geometry of one Unified Buffer word and of the host beat stream.
   localparam int DEF_ADDRESSSIZE = 10;
   localparam int DEF_DATA_BW     = 8;
   localparam int DEF_MATRIX_SIZE = 64;
   localparam int DEF_BEAT_BW     = 32;

   // Derived sizes for the default geometry.
   localparam int WORDSIZE       = DEF_DATA_BW * DEF_MATRIX_SIZE;
   localparam int BEATS_PER_WORD = WORDSIZE / DEF_BEAT_BW;
   localparam int BEAT_IDX_W     = $clog2(BEATS_PER_WORD);

   // Loader control states; encoding is fixed so it can be read from a probe.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Bits in one UB word for a given element width and row length.
   function automatic int calc_wordsize(input int data_bw, input int matrix_size);
      return data_bw * matrix_size;
   endfunction

   // Beats needed to assemble one UB word.
   function automatic int calc_beats(input int word_bits, input int beat_bw);
      return word_bits / beat_bw;
   endfunction

   // Beat-index counter width; never narrower than one bit.
   function automatic int calc_idx_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/ub_word_loader_if.sv
// Beat stream plus UB write port of the word loader.
// master = host/UB side, slave = the loader itself.
interface ub_word_loader_if
   import ub_loader_pkg::*;
#(
   parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
   parameter int WORD_BITS   = WORDSIZE,
   parameter int BEAT_BW     = DEF_BEAT_BW
);
   logic                   s_valid;
   logic                   s_ready;
   logic [BEAT_BW-1:0]     s_data;
   logic                   ub_write_enable;
   logic [ADDRESSSIZE-1:0] ub_address;
   logic [WORD_BITS-1:0]   ub_data_in;

   modport master (
      output s_valid, s_data,
      input  s_ready, ub_write_enable, ub_address, ub_data_in
   );

   modport slave (
      input  s_valid, s_data,
      output s_ready, ub_write_enable, ub_address, ub_data_in
   );
endinterface

// File: rtl/ub_word_loader_beat_packer.sv
// Beat packer: counts beats within a word and steers each beat into its lane.
// Beat k lands in word[k*BEAT_BW +: BEAT_BW], so element 0 is the low byte of beat 0.
module beat_packer
   import ub_loader_pkg::*;
#(
   parameter int BEAT_BW = DEF_BEAT_BW,
   parameter int N_BEATS = BEATS_PER_WORD,
   parameter int IDX_W   = BEAT_IDX_W
)(
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       clear,
   input  logic                       load,
   input  logic [BEAT_BW-1:0]         data,
   output logic                       last_beat,
   output logic [N_BEATS*BEAT_BW-1:0] word
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEATS - 1);

   logic [IDX_W-1:0] idx_reg;

   assign last_beat = (idx_reg == LAST_IDX);

   // Beat index: restarts on clear and wraps to lane 0 after the last lane.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_reg <= '0;
      end else if (clear) begin
         idx_reg <= '0;
      end else if (load) begin
         idx_reg <= last_beat ? '0 : idx_reg + IDX_W'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_BEATS; gi++) begin : g_lane
         logic [BEAT_BW-1:0] lane_reg;

         // Lane register captures the beat only when the index points at it.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               lane_reg <= '0;
            end else if (clear) begin
               lane_reg <= '0;
            end else if (load && (idx_reg == IDX_W'(gi))) begin
               lane_reg <= data;
            end
         end

         assign word[gi*BEAT_BW +: BEAT_BW] = lane_reg;
      end
   endgenerate

endmodule

// File: rtl/ub_word_loader.sv
// Unified Buffer word loader: packs host beats into UB words and writes them
// at consecutive (wrapping) addresses from a programmed base, then pulses done.
module ub_word_loader
   import ub_loader_pkg::*;
#(
   parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
   parameter int DATA_BW     = DEF_DATA_BW,
   parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
   parameter int BEAT_BW     = DEF_BEAT_BW
)(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   cfg_start,
   input  logic [ADDRESSSIZE-1:0] cfg_base_addr,
   input  logic [ADDRESSSIZE:0]   cfg_num_words,
   ub_word_loader_if.slave        bus,
   output logic                   busy,
   output logic                   done,
   output logic [ADDRESSSIZE:0]   word_count
);

   localparam int WORD_BITS = calc_wordsize(DATA_BW, MATRIX_SIZE);
   localparam int N_BEATS   = calc_beats(WORD_BITS, BEAT_BW);
   localparam int IDX_W     = calc_idx_w(N_BEATS);

   state_t                 state_reg;
   logic [ADDRESSSIZE-1:0] base_reg;
   logic [ADDRESSSIZE:0]   num_reg;
   logic [ADDRESSSIZE:0]   word_count_reg;
   logic [ADDRESSSIZE:0]   count_next;
   logic                   we_reg;
   logic [ADDRESSSIZE-1:0] addr_reg;
   logic [WORD_BITS-1:0]   data_reg;
   logic                   busy_reg;
   logic                   done_reg;

   logic                   s_ready_int;
   logic                   handshake;
   logic                   packer_clear;
   logic                   last_beat;
   logic [WORD_BITS-1:0]   packed_word;
   logic [WORD_BITS-1:0]   full_word;

   // Ready comes straight from the state register, never from s_valid.
   assign s_ready_int  = (state_reg == S_FILL);
   assign handshake    = bus.s_valid & s_ready_int;
   assign packer_clear = (state_reg == S_IDLE) & cfg_start;
   assign count_next   = word_count_reg + (ADDRESSSIZE + 1)'(1);

   beat_packer #(
      .BEAT_BW (BEAT_BW),
      .N_BEATS (N_BEATS),
      .IDX_W   (IDX_W)
   ) u_packer (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (packer_clear),
      .load      (handshake),
      .data      (bus.s_data),
      .last_beat (last_beat),
      .word      (packed_word)
   );

   // The final beat is still in flight when the write data is registered,
   // so merge it into the top lane here instead of waiting a cycle.
   always_comb begin
      full_word = packed_word;
      full_word[(N_BEATS-1)*BEAT_BW +: BEAT_BW] = bus.s_data;
   end

   // Loader FSM with registered UB drive, status and counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= S_IDLE;
         base_reg       <= '0;
         num_reg        <= '0;
         word_count_reg <= '0;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         data_reg       <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         we_reg   <= 1'b0;
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (cfg_start) begin
                  base_reg       <= cfg_base_addr;
                  num_reg        <= cfg_num_words;
                  word_count_reg <= '0;
                  busy_reg       <= 1'b1;
                  if (cfg_num_words == '0) begin
                     state_reg <= S_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (handshake && last_beat) begin
                  state_reg <= S_WRITE;
                  we_reg    <= 1'b1;
                  // Truncation to ADDRESSSIZE bits gives the wrap past the top.
                  addr_reg  <= base_reg + word_count_reg[ADDRESSSIZE-1:0];
                  data_reg  <= full_word;
               end
            end
            S_WRITE: begin
               word_count_reg <= count_next;
               if (count_next == num_reg) begin
                  state_reg <= S_DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg <= S_FILL;
               end
            end
            S_DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.s_ready         = s_ready_int;
   assign bus.ub_write_enable = we_reg;
   assign bus.ub_address      = addr_reg;
   assign bus.ub_data_in      = data_reg;
   assign busy                = busy_reg;
   assign done                = done_reg;
   assign word_count          = word_count_reg;

endmodule

// File: doc/ub_word_loader.md
# ub_word_loader

Host-side loader that feeds the Unified Buffer SRAM. It accepts a narrow valid/ready beat stream and packs `BEATS_PER_WORD` beats into one `WORDSIZE`-bit activation word. It writes each completed word into the UB at consecutive addresses from a programmed base, and pulses `done` when the programmed word count has been written. It drives the UB `write_enable`/`address`/`data_in` pins, which are otherwise host-driven.

## Interface
Parameters:
- `ADDRESSSIZE`, 10, UB address width.
- `DATA_BW`, 8, activation element width.
- `MATRIX_SIZE`, 64, elements per UB word; `WORDSIZE` = `DATA_BW*MATRIX_SIZE` = 512.
- `BEAT_BW`, 32, input beat width. Must divide `WORDSIZE`; `BEATS_PER_WORD` = `WORDSIZE/BEAT_BW` = 16.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  job start; sampled only in IDLE.
- `cfg_base_addr`  in  `ADDRESSSIZE`  first UB address; latched on accepted start.
- `cfg_num_words`  in  `ADDRESSSIZE+1`  words to write, 0..1024; latched on accepted start.
- `s_valid`  in  1  beat valid.
- `s_ready`  out  1  beat ready.
- `s_data`  in  `BEAT_BW`  beat payload.
- `ub_write_enable`  out  1  UB write strobe.
- `ub_address`  out  `ADDRESSSIZE`  UB write address.
- `ub_data_in`  out  `WORDSIZE`  UB write data.
- `busy`  out  1  high from accepted start until the `done` cycle, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `word_count`  out  `ADDRESSSIZE+1`  words written in the current or last job.

## Operation
- The FSM has four states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - `cfg_start`=1 latches base and count and clears `word_count`, beat index and pack register.
  - If count=0 go to DONE, else go to FILL.
- FILL:
  - `s_ready`=1. A handshake occurs when `s_valid & s_ready`.
  - Beat k (0-based within the word) is written to pack bits `[k*BEAT_BW +: BEAT_BW]`, so UB element 0 = bits [7:0] of the first beat.
  - On the handshake of beat `BEATS_PER_WORD-1`, go to WRITE.
  - `s_valid` gaps stall without loss; `s_data` is ignored when no handshake occurs.
- WRITE:
  - `s_ready`=0. `ub_write_enable`=1 for exactly this cycle.
  - `ub_address` = (base + `word_count`) mod 2^`ADDRESSSIZE`, i.e. wraps 0x3FF→0x000.
  - `ub_data_in` = pack register.
  - Next cycle `word_count`+1. Go to DONE if the new count equals the latched count, else go to FILL with beat index 0.
- DONE: `done`=1 for one cycle, then go to IDLE. `word_count` holds until the next accepted start.
- `cfg_start` outside IDLE is ignored; config changes mid-job have no effect.
- Reset, including mid-job, returns to IDLE and clears every register and output to 0. A partial word is discarded, not written.

## Timing
- Reset values: `s_ready`=0, `ub_write_enable`=0, `ub_address`=0, `ub_data_in`=0, `busy`=0, `done`=0, `word_count`=0.
- `ub_*`, `busy`, `done` and `word_count` are registered. `s_ready` is decoded directly from the state register, with no combinational path from `s_valid`.
- Start accepted at edge T:
  - FILL is entered from T+1, so the first beat can be accepted at edge T+1.
  - At full rate, a word's write cycle follows its 16th beat by one cycle: 17 cycles per word.
  - `done` asserts the cycle after the last WRITE.
- num_words=0: `done` is high in cycle T+1 and no write occurs.
- `ub_address`/`ub_data_in` hold their last written values when `ub_write_enable`=0.

## Structure
- Shared package `ub_loader_pkg` holds:
  - the `WORDSIZE`/`BEATS_PER_WORD` localparam derivations;
  - the state enum (IDLE=0, FILL=1, WRITE=2, DONE=3);
  - a `$clog2(BEATS_PER_WORD)` beat-index width constant.
- One sub-module, `beat_packer`: beat-index counter plus lane-indexed pack register, with `clear`, `load`, `data` inputs and `last_beat` and `word` outputs. The top holds the FSM, the address/word counters and the UB drive registers.

## Test plan
- **Single word:** base=0x010, num=1, 16 beats 0x03020100, 0x07060504, …, 0x3F3E3D3C at full rate.
  - One `ub_write_enable` pulse, address 0x010, `ub_data_in` bytes 0..63 = 0x00..0x3F.
  - `done` arrives 18 cycles after start; `word_count`=1.
- **Address wrap:** base=0x3FF, num=2 → writes at 0x3FF then 0x000; `word_count`=2.
- **Zero length:** num=0 → `done` at T+1, no write, `busy` high for exactly 1 cycle.
- **Backpressure:** `s_valid` toggles 1/0 every cycle for the single-word case → data identical to the full-rate run, and `s_ready` is low in the WRITE cycle.
- **Start while busy:** `cfg_start` pulsed with new base=0x200 mid-FILL → ignored; the original job's addresses are unchanged.
- **Reset mid-job:** `rstn` dropped after 5 beats of word 0 → all outputs 0 immediately with no write. A new job (base=0x000, num=1) then completes with correct data.
